// File: rtl/morph_frame_ctrl.sv
// rtl/morph_frame_ctrl.sv - frame-synchronous mode, position and geometry controller for the morphology path
// Mode requests are held pending and only take effect on a frame start, so no frame mixes modes.
module morph_frame_ctrl #(
  parameter logic [9:0] IMG_HDISP  = 10'd800,
  parameter logic [9:0] IMG_VDISP  = 10'd600,
  parameter logic [2:0] RESET_MODE = 3'd2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       per_frame_vsync,
  input  logic       per_frame_href,
  input  logic       per_frame_clken,
  input  logic [2:0] cfg_mode,
  input  logic       cfg_valid,
  output logic       cfg_ready,
  output logic [2:0] morph_mode,
  output logic       mode_apply,
  output logic [9:0] pix_x,
  output logic [9:0] pix_y,
  output logic       border_flag,
  output logic       frame_done,
  output logic       frame_err,
  output logic [7:0] frame_cnt
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BLANK  = 2'd1,
    ACTIVE = 2'd2
  } state_t;

  localparam logic [9:0] PIX_MAX = 10'h3ff;
  localparam logic [9:0] X_LAST  = IMG_HDISP - 10'd1;
  localparam logic [9:0] Y_LAST  = IMG_VDISP - 10'd1;

  state_t     state;
  state_t     state_nxt;
  logic       vsync_d;
  logic       href_d;
  logic       frame_start;
  logic       frame_end;
  logic       line_end;
  logic       pending_valid;
  logic [2:0] pending_mode;
  logic [2:0] cfg_mode_dec;
  logic       cfg_accept;
  logic       apply_now;
  logic       line_err;
  logic       pixel_in;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vsync_d <= 1'b0;
      href_d  <= 1'b0;
    end else begin
      vsync_d <= per_frame_vsync;
      href_d  <= per_frame_href;
    end
  end

  assign frame_start = per_frame_vsync & ~vsync_d;
  assign frame_end   = ~per_frame_vsync & vsync_d;
  assign line_end    = ~per_frame_href & href_d;
  assign pixel_in    = per_frame_href & per_frame_clken;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // IDLE only leaves once vsync is low, so a reset mid-frame never joins a partial frame.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (!per_frame_vsync) state_nxt = BLANK;
      BLANK:   if (frame_start) state_nxt = ACTIVE;
      ACTIVE:  if (frame_end) state_nxt = BLANK;
      default: state_nxt = IDLE;
    endcase
  end

  assign cfg_mode_dec = (cfg_mode > 3'd4) ? 3'd0 : cfg_mode;
  assign cfg_ready    = ~pending_valid;
  assign cfg_accept   = cfg_valid & ~pending_valid;
  // Only a request already pending before this frame start is applied.
  assign apply_now    = frame_start & pending_valid & (state == BLANK);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_valid <= 1'b0;
      pending_mode  <= 3'd0;
      morph_mode    <= RESET_MODE;
      mode_apply    <= 1'b0;
    end else begin
      mode_apply <= 1'b0;
      if (apply_now) begin
        pending_valid <= 1'b0;
        morph_mode    <= pending_mode;
        mode_apply    <= 1'b1;
      end else if (cfg_accept) begin
        pending_valid <= 1'b1;
        pending_mode  <= cfg_mode_dec;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pix_x    <= 10'd0;
      pix_y    <= 10'd0;
      line_err <= 1'b0;
    end else if (frame_start) begin
      pix_x    <= 10'd0;
      pix_y    <= 10'd0;
      line_err <= 1'b0;
    end else if (state == ACTIVE) begin
      if (line_end) begin
        pix_x <= 10'd0;
        if (pix_y != PIX_MAX) pix_y <= pix_y + 10'd1;
        if (pix_x != IMG_HDISP) line_err <= 1'b1;
      end else if (pixel_in && (pix_x != PIX_MAX)) begin
        pix_x <= pix_x + 10'd1;
      end
    end
  end

  // A vsync fall outside ACTIVE is spurious and leaves the frame status untouched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
      frame_cnt  <= 8'd0;
    end else begin
      frame_done <= 1'b0;
      if (frame_end && (state == ACTIVE)) begin
        frame_done <= 1'b1;
        frame_err  <= line_err | (pix_y != IMG_VDISP);
        frame_cnt  <= frame_cnt + 8'd1;
      end
    end
  end

  assign border_flag = pixel_in & (state == ACTIVE) &
                       ((pix_x == 10'd0) | (pix_x == X_LAST) |
                        (pix_y == 10'd0) | (pix_y == Y_LAST));

endmodule
